map_frame_writer: RTL and testbench
===================================

# map_frame_writer

Producer side of the map-generator cell-write port. Accepts a complete COLS×ROWS wall bitmap from game logic through a valid/ready handshake and compares it against a shadow copy of what the map generator already holds. It then streams one cell write (x, y, dataIn, gated switchBuffer strobe) for each differing cell. Between them, the game core and the map generator carry only changed cells per frame.

## Interface
- COLS, 14, map columns (x range 0..COLS-1)
- ROWS, 8, map rows (y range 0..ROWS-1)
- clk  in  1  single system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- frame_in  in  COLS*ROWS  bitmap; cell (x,y) = frame_in[y*COLS+x]; 1 = wall
- frame_valid  in  1  frame_in valid
- frame_ready  out  1  high only in IDLE; transfer on frame_valid & frame_ready
- force_all  in  1  sampled at transfer; 1 = write every cell regardless of shadow
- x  out  8  column of current write
- y  out  8  row of current write
- dataIn  out  8  {7'b0, cell value}
- switchBuffer  out  1  one-cycle write strobe
- toggle  out  1  write-window gate; the sink writes on the rising edge of toggle & switchBuffer
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a frame finishes
- write_count  out  8  number of cell writes issued for the last frame; valid from frame_done onward

## Operation
- States: IDLE, SCAN, SETUP, STROBE, HOLD, DONE.
- IDLE: frame_ready=1. On transfer, capture frame_in into frame_q and force_all into force_q. Clear idx and write_count. Go to SCAN.
- SCAN (idx = y*COLS+x, row-major, idx 0..COLS*ROWS-1): a cell is changed if frame_q[idx] != shadow[idx] or force_q.
  - Changed cell: go to SETUP.
  - Unchanged cell with idx < last: increment idx and stay in SCAN.
  - Unchanged cell with idx = last: go to DONE.
- SETUP: drive x, y, and dataIn for idx; toggle=1, switchBuffer=0.
- STROBE: switchBuffer=1, toggle=1; x, y, dataIn held.
- HOLD: switchBuffer=0, toggle=1; x, y, dataIn held. Set shadow[idx] <= frame_q[idx] and increment write_count. If idx = last, go to DONE; otherwise increment idx and go to SCAN.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- x and y are kept as separate counters (x wraps at COLS-1 and increments y). No division is used. x, y, and dataIn hold their last values outside SETUP/STROBE/HOLD.
- Shadow reset value is all ones, matching the map generator's power-up content.
- frame_valid while busy is ignored, with no queuing. frame_in and force_all may change freely after transfer.
- Reset mid-frame: all state clears immediately. The map generator may then hold a partially updated map; game logic must send the next frame with force_all=1 to resync.

## Timing
- Reset values: frame_ready=1, busy=0, frame_done=0, switchBuffer=0, toggle=0, x=0, y=0, dataIn=0, write_count=0, state IDLE.
- Transfer edge = cycle 0. Cycles 1.. are SCAN. Each unchanged cell costs 1 cycle; each changed cell costs 4 cycles (SCAN, SETUP, STROBE, HOLD).
- With N writes and C = COLS*ROWS (112 by default): frame_done is high in cycle C+3N+1, and frame_ready returns high in cycle C+3N+2.
- Worst case (force_all): 449 cycles to frame_done.
- x, y, and dataIn are stable one cycle before switchBuffer rises and one cycle after it falls.
- toggle is never high outside SETUP..HOLD. switchBuffer is never high outside STROBE.
- write_count maximum is C (112), which fits 8 bits with no saturation needed.

## Test plan
- After reset, transfer all-ones frame with force_all=0 -> no switchBuffer pulses; frame_done in cycle 113; write_count=0.
- Transfer all-ones except cell (3,2)=0 -> exactly one strobe with x=3, y=2, dataIn=0; frame_done in cycle 116; write_count=1.
- Resend the same frame -> zero writes. Then set (13,7) back to 1 -> one strobe x=13, y=7, dataIn=1 as the final write; frame_done cycle 116.
- force_all=1, any frame -> 112 strobes in row-major order (0,0)..(13,7); frame_done cycle 449; write_count=112; each strobe has toggle=1 with x/y/dataIn stable ±1 cycle.
- Hold frame_valid high with a different frame_in during a busy frame -> second frame taken only in the first IDLE cycle after DONE.
- Assert rst during STROBE -> switchBuffer, toggle, and busy drop immediately and frame_ready=1. A following unchanged all-ones frame issues 0 writes; with force_all=1 it issues 112.

Source files
------------

// File: rtl/map_frame_writer_if.sv
// Frame handshake and cell-write port between game logic, map_frame_writer and the map generator.
// master = game-logic side, slave = map_frame_writer.
interface map_frame_writer_if #(
  parameter int COLS = 14,
  parameter int ROWS = 8
);
  localparam int CELLS = COLS * ROWS;

  logic [CELLS-1:0] frame_in;
  logic             frame_valid;
  logic             frame_ready;
  logic             force_all;
  logic [7:0]       x;
  logic [7:0]       y;
  logic [7:0]       dataIn;
  logic             switchBuffer;
  logic             toggle;
  logic             busy;
  logic             frame_done;
  logic [7:0]       write_count;

  modport master (
    output frame_in, frame_valid, force_all,
    input  frame_ready, x, y, dataIn, switchBuffer, toggle, busy, frame_done, write_count
  );

  modport slave (
    input  frame_in, frame_valid, force_all,
    output frame_ready, x, y, dataIn, switchBuffer, toggle, busy, frame_done, write_count
  );
endinterface

// File: rtl/map_frame_writer.sv
// Diffs each incoming wall bitmap against a shadow of the map generator's content and
// streams one SETUP/STROBE/HOLD cell write per changed cell, row-major.
module map_frame_writer #(
  parameter int COLS = 14,
  parameter int ROWS = 8
) (
  input logic               clk,
  input logic               rst,
  map_frame_writer_if.slave bus
);
  localparam int CELLS = COLS * ROWS;
  localparam int IW    = $clog2(CELLS);

  typedef enum logic [2:0] {IDLE, SCAN, SETUP, STROBE, HOLD, DONE} state_t;

  state_t           state;
  logic [CELLS-1:0] frame_q;
  logic [CELLS-1:0] shadow;
  logic             force_q;
  logic [IW-1:0]    idx;
  logic [7:0]       cx, cy;
  logic [7:0]       x_q, y_q, data_q;
  logic             strobe_q, toggle_q, ready_q, busy_q, done_q;
  logic [7:0]       count_q;

  logic             last_cell;
  logic             changed;
  logic [7:0]       cx_next, cy_next;

  assign last_cell = (idx == IW'(CELLS - 1));
  assign changed   = force_q | (frame_q[idx] != shadow[idx]);
  assign cx_next   = (cx == 8'(COLS - 1)) ? 8'd0 : cx + 8'd1;
  assign cy_next   = (cx == 8'(COLS - 1)) ? cy + 8'd1 : cy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      frame_q  <= '0;
      // NOTE: the shadow is a register file that must be reset: its all-ones value mirrors
      // the map generator's power-up content, so the first diff is against real data.
      shadow   <= '1;
      force_q  <= 1'b0;
      idx      <= '0;
      cx       <= 8'd0;
      cy       <= 8'd0;
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      data_q   <= 8'd0;
      strobe_q <= 1'b0;
      toggle_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_valid) begin
            frame_q <= bus.frame_in;
            force_q <= bus.force_all;
            idx     <= '0;
            cx      <= 8'd0;
            cy      <= 8'd0;
            count_q <= 8'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (changed) begin
            x_q      <= cx;
            y_q      <= cy;
            data_q   <= {7'b0, frame_q[idx]};
            toggle_q <= 1'b1;
            state    <= SETUP;
          end else if (last_cell) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + IW'(1);
            cx  <= cx_next;
            cy  <= cy_next;
          end
        end
        SETUP: begin
          strobe_q <= 1'b1;
          state    <= STROBE;
        end
        STROBE: begin
          strobe_q <= 1'b0;
          state    <= HOLD;
        end
        HOLD: begin
          // toggle drops as HOLD ends so the write window covers exactly SETUP..HOLD.
          toggle_q    <= 1'b0;
          shadow[idx] <= frame_q[idx];
          count_q     <= count_q + 8'd1;
          if (last_cell) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx   <= idx + IW'(1);
            cx    <= cx_next;
            cy    <= cy_next;
            state <= SCAN;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.frame_ready  = ready_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = done_q;
  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.dataIn       = data_q;
  assign bus.switchBuffer = strobe_q;
  assign bus.toggle       = toggle_q;
  assign bus.write_count  = count_q;
endmodule

// File: tb/tb_map_frame_writer.sv
// Self-checking bench for map_frame_writer: random and directed frames scored against a
// shadow-bitmap reference model of which cells must be written and when the frame ends.
module tb_map_frame_writer;
  localparam int COLS  = 14;
  localparam int ROWS  = 8;
  localparam int CELLS = COLS * ROWS;
  localparam int BOUND = 600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  map_frame_writer_if #(.COLS(COLS), .ROWS(ROWS)) bus ();
  map_frame_writer #(.COLS(COLS), .ROWS(ROWS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [CELLS-1:0] model_shadow;

  logic [7:0] hx [BOUND+2];
  logic [7:0] hy [BOUND+2];
  logic [7:0] hd [BOUND+2];
  logic       htg[BOUND+2];

  function automatic logic [CELLS-1:0] rand_frame();
    logic [CELLS-1:0] f;
    for (int i = 0; i < CELLS; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  task automatic start_frame(input logic [CELLS-1:0] f, input logic fa, input bit keep_valid);
    int waited = 0;
    @(negedge clk);
    while (bus.frame_ready !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (bus.frame_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_ready: frame_ready=%0b required 1", bus.frame_ready);
    end
    bus.frame_in    = f;
    bus.force_all   = fa;
    bus.frame_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      bus.frame_valid = 1'b0;
      bus.frame_in    = rand_frame();
      bus.force_all   = 1'($urandom_range(0, 1));
    end
  endtask

  // Called just after the transfer edge; returns at the negedge of cycle done+1.
  task automatic watch_frame(input string name, input logic [CELLS-1:0] f, input logic fa);
    int exp_idx[$];
    logic exp_val[$];
    int strobes[$];
    int done_cyc = -1;
    int ntg = 0;
    int exp_n, exp_done, nchk;
    for (int i = 0; i < CELLS; i++) begin
      if (fa || f[i] !== model_shadow[i]) begin
        exp_idx.push_back(i);
        exp_val.push_back(f[i]);
        model_shadow[i] = f[i];
      end
    end
    exp_n    = exp_idx.size();
    exp_done = CELLS + 3 * exp_n + 1;

    for (int c = 1; c <= BOUND; c++) begin
      @(negedge clk);
      hx[c] = bus.x; hy[c] = bus.y; hd[c] = bus.dataIn; htg[c] = bus.toggle;
      if (c == 1) begin
        total++;
        if (bus.busy !== 1'b1 || bus.frame_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s busy_c1: busy=%0b ready=%0b required 1/0", name, bus.busy, bus.frame_ready);
        end
      end
      if (bus.switchBuffer === 1'b1) strobes.push_back(c);
      if (bus.toggle === 1'b1) ntg++;
      if (bus.frame_done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end

    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("FAIL %s timeout: no frame_done within %0d cycles, required at %0d", name, BOUND, exp_done);
      return;
    end
    total++;
    if (done_cyc != exp_done) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_done);
    end
    total++;
    if (strobes.size() != exp_n) begin
      bad++;
      $display("FAIL %s strobe_count: got %0d required %0d", name, strobes.size(), exp_n);
    end
    total++;
    if (ntg != 3 * exp_n) begin
      bad++;
      $display("FAIL %s toggle_cycles: got %0d required %0d", name, ntg, 3 * exp_n);
    end
    total++;
    if (bus.write_count !== 8'(exp_n)) begin
      bad++;
      $display("FAIL %s write_count: got %0d required %0d", name, bus.write_count, exp_n);
    end

    nchk = (strobes.size() < exp_n) ? strobes.size() : exp_n;
    for (int k = 0; k < nchk; k++) begin
      int c = strobes[k];
      logic [23:0] got, want;
      got  = {hx[c], hy[c], hd[c]};
      want = {8'(exp_idx[k] % COLS), 8'(exp_idx[k] / COLS), 7'b0, exp_val[k]};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s write%0d: x/y/d=%0d/%0d/%0d required %0d/%0d/%0d", name, k,
                 hx[c], hy[c], hd[c], want[23:16], want[15:8], want[7:0]);
      end
      total++;
      if ({hx[c-1], hy[c-1], hd[c-1]} !== got || {hx[c+1], hy[c+1], hd[c+1]} !== got ||
          htg[c-1] !== 1'b1 || htg[c] !== 1'b1 || htg[c+1] !== 1'b1) begin
        bad++;
        $display("FAIL %s window%0d: x/y/d/toggle not stable around strobe at cycle %0d", name, k, c);
      end
    end

    @(negedge clk);
    total++;
    if (bus.frame_done !== 1'b0 || bus.frame_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: done=%0b ready=%0b busy=%0b required 0/1/0", name,
               bus.frame_done, bus.frame_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.frame_valid = 1'b0;
    bus.frame_in    = '1;
    bus.force_all   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.frame_ready, bus.busy, bus.frame_done, bus.switchBuffer, bus.toggle} !== 5'b10000 ||
        {bus.x, bus.y, bus.dataIn, bus.write_count} !== 32'd0) begin
      bad++;
      $display("FAIL reset: ready/busy/done/sb/tg=%b x=%0d y=%0d d=%0d wc=%0d required 10000 and zeros",
               {bus.frame_ready, bus.busy, bus.frame_done, bus.switchBuffer, bus.toggle},
               bus.x, bus.y, bus.dataIn, bus.write_count);
    end
    rst = 1'b0;
    model_shadow = '1;
  endtask

  task automatic test_directed();
    logic [CELLS-1:0] a, b;
    a = '1;
    a[2*COLS+3] = 1'b0;
    b = a;
    b[7*COLS+13] = 1'b0;
    start_frame('1, 1'b0, 1'b0); watch_frame("all_ones", '1, 1'b0);
    start_frame(a, 1'b0, 1'b0);  watch_frame("cell_3_2", a, 1'b0);
    start_frame(a, 1'b0, 1'b0);  watch_frame("resend", a, 1'b0);
    start_frame(b, 1'b0, 1'b0);  watch_frame("clear_13_7", b, 1'b0);
    start_frame(a, 1'b0, 1'b0);  watch_frame("set_13_7", a, 1'b0);
  endtask

  task automatic test_force();
    logic [CELLS-1:0] f;
    f = rand_frame();
    start_frame(f, 1'b1, 1'b0);
    watch_frame("force_all", f, 1'b1);
  endtask

  task automatic test_random();
    logic [CELLS-1:0] f;
    for (int n = 0; n < 5; n++) begin
      f = model_shadow;
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) f[$urandom_range(0, CELLS - 1)] ^= 1'b1;
      start_frame(f, 1'b0, 1'b0);
      watch_frame("random_sparse", f, 1'b0);
    end
    f = rand_frame();
    start_frame(f, 1'b0, 1'b0);
    watch_frame("random_dense", f, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [CELLS-1:0] f1, f2;
    f1 = rand_frame();
    f2 = rand_frame();
    start_frame(f1, 1'b0, 1'b1);
    bus.frame_in  = f2;
    bus.force_all = 1'b0;
    watch_frame("b2b_first", f1, 1'b0);
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
    bus.frame_in    = rand_frame();
    watch_frame("b2b_second", f2, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int w = 0;
    start_frame('1, 1'b1, 1'b0);
    @(negedge clk);
    while (bus.switchBuffer !== 1'b1 && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (bus.switchBuffer !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_reach: switchBuffer=%0b required 1", bus.switchBuffer);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.switchBuffer, bus.toggle, bus.busy, bus.frame_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL rst_mid: sb/tg/busy/ready=%b required 0001",
               {bus.switchBuffer, bus.toggle, bus.busy, bus.frame_ready});
    end
    #1;
    rst = 1'b0;
    model_shadow = '1;
    start_frame('1, 1'b0, 1'b0);
    watch_frame("rst_unchanged", '1, 1'b0);
    start_frame('1, 1'b1, 1'b0);
    watch_frame("rst_resync", '1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_force();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
